shared_adder_arbiter: RTL and testbench
=======================================

# shared_adder_arbiter

Round-robin arbiter and sequencer that shares a single 8-bit adder datapath between `NREQ` requesters. Each requester presents two operands under a valid/ready handshake. The block grants one requester at a time, registers the sum, carry and requester ID, and holds the result on a response handshake until it is accepted. It sits between the tile's input-pin decoding logic and the `uo_out` driver in the top-level TinyTapeout wrapper.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand and sum width.
- `IDW`, default `$clog2(NREQ)`: requester-ID width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ena`  in  1  grant enable; when low, no new grants are issued.
- `req_valid`  in  NREQ  per-requester request.
- `req_ready`  out  NREQ  per-requester grant/accept, one-hot or zero.
- `req_a`  in  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  WIDTH  registered sum.
- `rsp_carry`  out  1  carry out of the WIDTH-bit add.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `busy`  out  1  high while in state RESP.
- `op_count`  out  16  number of completed responses, saturating.

## Operation
- The FSM has two states, IDLE and RESP. Reset puts it in IDLE.
- **IDLE:**
  - If `ena`=1 and any `req_valid` is set, grant the first valid requester found searching upward from `rr_ptr` with wrap-around.
  - `req_ready[g]` is combinational and asserts in that same cycle.
  - On the clock edge:
    - `{rsp_carry, rsp_sum} <= req_a[g] + req_b[g]`, computed at WIDTH+1 bits.
    - `rsp_id <= g`.
    - State moves to RESP.
  - If `ena`=0 or no request is valid, `req_ready` is all zero and the FSM stays in IDLE.
- **RESP:**
  - `rsp_valid`=1, `busy`=1, and `req_ready`=0.
  - `rsp_sum`, `rsp_carry` and `rsp_id` stay stable until accepted.
  - When `rsp_ready`=1:
    - Return to IDLE.
    - `rr_ptr <= (rsp_id+1) mod NREQ`.
    - `op_count` increments, saturating at 0xFFFF.
- Requester obligations: hold `req_valid` and the operands stable until `req_ready` is seen. The block samples operands only in the grant cycle.
- Dropping `req_valid` before grant is legal; that request is simply never granted.
- Driving `ena` low while in RESP does not abort the response. It only blocks the next grant.
- Fairness: a requester that holds `req_valid` high is granted within NREQ responses.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_carry`=0, `rsp_id`=0, `busy`=0, `op_count`=0, `rr_ptr`=0.
- Latency is 1 cycle from grant to `rsp_valid`. If the grant happens in cycle N, `rsp_valid` goes high in cycle N+1.
- Minimum spacing is 2 cycles per operation: grant in IDLE, then accept in RESP with `rsp_ready`=1.
- No grant is issued in the same cycle as a response acceptance. The next grant comes no earlier than the cycle after acceptance.
- Wrap-around: with `rr_ptr`=NREQ-1, the search order is NREQ-1, 0, 1, and so on.
- Overflow: the carry is reported and, by default, `rsp_sum` wraps modulo 2^WIDTH.
- Reset mid-operation: an asserted `rst_n` clears all state immediately. Any pending response is discarded and `rsp_valid` drops asynchronously.

## Configuration
- Macro `SHARED_ADDER_SAT_EN`.
- When defined: the adder saturates, so if the carry is 1, `rsp_sum` is all ones (0xFF for WIDTH=8). `rsp_carry` still reports the raw carry.
- When not defined: `rsp_sum` is the modulo-2^WIDTH sum.
- Handshake and timing are identical in both builds.

## Test plan
- Single request: requester 2 with a=0x12, b=0x34. Expect `req_ready`=4'b0100 in the request cycle, and next cycle `rsp_valid`=1, `rsp_sum`=0x46, `rsp_carry`=0, `rsp_id`=2. With `rsp_ready`=1, `op_count`=1.
- Round-robin: all four requests held continuously with `rsp_ready`=1. Expect grant order 0, 1, 2, 3, 0, with each grant 2 cycles apart.
- Overflow: a=0xF0, b=0x20.
  - Default build: `rsp_sum`=0x10, `rsp_carry`=1.
  - With `SHARED_ADDER_SAT_EN`: `rsp_sum`=0xFF, `rsp_carry`=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with requester 1 valid. Expect `rsp_sum`/`rsp_id` stable, `req_ready`=0 throughout, and no second grant until 1 cycle after acceptance.
- Enable gating and reset: with `ena`=0 and requests valid, expect no `req_ready` for 10 cycles. Then drive `rst_n` low while in RESP. Expect `rsp_valid`, `busy` and `op_count` to go to 0 immediately and the FSM to restart in IDLE with `rr_ptr`=0.

Source files
------------

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ valid/ready requesters.
// Optional build macro SHARED_ADDER_SAT_EN makes the sum saturate to all ones on carry-out.
module shared_adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_carry,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy,
    output logic [15:0]             op_count
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr, ptr_nxt, gnt_id_p0, id_p1;
    logic             gnt_found_p0, grant_p0, accept;
    logic [WIDTH-1:0] a_p0, b_p0, sum_p1;
    logic [WIDTH:0]   sum_full_p0;
    logic             carry_p1;
    logic [15:0]      op_count_q;

    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH:0] full);
`ifdef SHARED_ADDER_SAT_EN
        sat_sum = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
        sat_sum = full[WIDTH-1:0];
`endif
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        sat_inc16 = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // p0: round-robin search from rr_ptr, operand mux and add
    always_comb begin
        logic [IDW:0]   idx;
        logic [IDW-1:0] cand;
        gnt_found_p0 = 1'b0;
        gnt_id_p0    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            cand = idx[IDW-1:0];
            if (!gnt_found_p0 && req_valid[cand]) begin
                gnt_found_p0 = 1'b1;
                gnt_id_p0    = cand;
            end
        end
    end

    always_comb begin
        a_p0 = '0;
        b_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id_p0 == IDW'(i)) begin
                a_p0 = req_a[i*WIDTH +: WIDTH];
                b_p0 = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_full_p0 = {1'b0, a_p0} + {1'b0, b_p0};
    assign grant_p0    = (state == IDLE) && ena && gnt_found_p0;
    assign req_ready   = grant_p0 ? (NREQ'(1) << gnt_id_p0) : '0;
    assign accept      = (state == RESP) && rsp_ready;
    assign ptr_nxt     = (id_p1 == IDW'(NREQ-1)) ? '0 : id_p1 + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_p0) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // p1: registered response, held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1     <= '0;
            carry_p1   <= 1'b0;
            id_p1      <= '0;
            rr_ptr     <= '0;
            op_count_q <= '0;
        end else begin
            if (grant_p0) begin
                sum_p1   <= sat_sum(sum_full_p0);
                carry_p1 <= sum_full_p0[WIDTH];
                id_p1    <= gnt_id_p0;
            end
            if (accept) begin
                rr_ptr     <= ptr_nxt;
                op_count_q <= sat_inc16(op_count_q);
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state == RESP);
    assign rsp_sum   = sum_p1;
    assign rsp_carry = carry_p1;
    assign rsp_id    = id_p1;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Scoreboard bench for shared_adder_arbiter: reference arbiter model predicts grants and
// pushes expected results; a monitor pops and compares whenever a response is presented.
module tb_shared_adder_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n, ena, rsp_ready;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_carry, busy;
    logic [W-1:0]   rsp_sum;
    logic [1:0]     rsp_id;
    logic [15:0]    op_count;
    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic [1:0] id;
    } rsp_t;

    rsp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int m_busy  = 0;
    int m_ptr   = 0;
    int m_id    = 0;
    int m_cnt   = 0;
    int last_gnt = -1;

    shared_adder_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_arr[i];
            req_b[i*W +: W] = b_arr[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid requester at or above ptr, wrapping around.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic rsp_t model_add(input int a, input int b, input int id);
        rsp_t r;
        int s;
        s = a + b;
        r.carry = (s > 255);
`ifdef SHARED_ADDER_SAT_EN
        r.sum = (s > 255) ? 8'hFF : 8'(s % 256);
`else
        r.sum = 8'(s % 256);
`endif
        r.id = 2'(id);
        return r;
    endfunction

    // Reference model: checks control outputs, predicts grants, queues expected results.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; last_gnt = -1;
            exp_q.delete();
        end else begin
            g = (m_busy == 0 && ena) ? pick(req_valid, m_ptr) : -1;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), m_busy);
            chk("rsp_valid", 32'(rsp_valid), m_busy);
            chk("op_count", 32'(op_count), m_cnt);
            last_gnt = g;
            if (g >= 0) begin
                exp_q.push_back(model_add(int'(a_arr[g]), int'(b_arr[g]), g));
                m_busy = 1;
                m_id = g;
            end else if (m_busy != 0 && rsp_ready) begin
                m_busy = 0;
                m_ptr = (m_id + 1) % N;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    end

    // Monitor: every presented response is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d sum %0h, expected no response", rsp_id, rsp_sum);
            end else begin
                chk("rsp_sum", 32'(rsp_sum), 32'(exp_q[0].sum));
                chk("rsp_carry", 32'(rsp_carry), 32'(exp_q[0].carry));
                chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rr_exp [10];
        logic [7:0]   ovf_sum;
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        rst_n = 1'b0; ena = 1'b0; rsp_ready = 1'b0; req_valid = '0;
        for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_sum", 32'(rsp_sum), 0);
        chk("reset_carry", 32'(rsp_carry), 0);
        chk("reset_id", 32'(rsp_id), 0);
        chk("reset_op_count", 32'(op_count), 0);
        step();
        rst_n = 1'b1;

        // Round robin: all requesters held, consumer always ready
        ena = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < N; i++) begin a_arr[i] = 8'(i * 16); b_arr[i] = 8'(i + 1); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(rr_exp[c]));
            step();
        end
        req_valid = '0;

        // Single request from requester 2
        a_arr[2] = 8'h12; b_arr[2] = 8'h34; req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_sum", 32'(rsp_sum), 32'h46);
        chk("single_carry", 32'(rsp_carry), 0);
        chk("single_id", 32'(rsp_id), 2);
        step();
        @(negedge clk);
        chk("single_count", 32'(op_count), 6);

        // Overflow
        step();
        a_arr[0] = 8'hF0; b_arr[0] = 8'h20; req_valid = 4'b0001;
        step();
        req_valid = '0;
`ifdef SHARED_ADDER_SAT_EN
        ovf_sum = 8'hFF;
`else
        ovf_sum = 8'h10;
`endif
        @(negedge clk);
        chk("ovf_sum", 32'(rsp_sum), 32'(ovf_sum));
        chk("ovf_carry", 32'(rsp_carry), 1);
        step();

        // Backpressure with requester 1 held valid
        a_arr[1] = 8'($urandom); b_arr[1] = 8'($urandom);
        req_valid = 4'b0010; rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_id", 32'(rsp_id), 1);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_ready", 32'(req_ready), 0);
        step();
        @(negedge clk);
        chk("bp_regrant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step();

        // Enable gating, then asynchronous reset in RESP
        ena = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("ena_gate", 32'(req_ready), 0);
        end
        step();
        ena = 1'b1;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_op_count", 32'(op_count), 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_restart_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0; rsp_ready = 1'b1;
        step();

        // Randomized traffic under protocol rules
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_gnt == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    a_arr[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                    b_arr[i] = 8'($urandom);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    a_arr[i] = 8'($urandom);
                    b_arr[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                end
            end
            ena = ($urandom_range(0, 7) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        ena = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (4) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
